// File: rtl/bit_population_accumulator.sv
// bit_population_accumulator
//   Streaming population counter that sums the set bits of every word in a
//   frame (frame ends on the word flagged with data_last_i) and emits one
//   saturating count per frame.
//
//   Datapath: input register -> PIPE_SIZE-stage adder tree (per-word count)
//   -> accumulator FSM (ACC / OUT) holding the frame result.
//
// Parameters
//   WIDTH      input word width in bits (>= 2)
//   PIPE_SIZE  register stages in the per-word adder tree (1..$clog2(WIDTH))
//   CNT_W      frame count width (>= $clog2(WIDTH)+1)
//
// Ports
//   clk_i         clock
//   arst_n_i      asynchronous active-low reset
//   data_i        input word
//   data_last_i   word is the last of its frame
//   data_val_i    input word valid
//   data_ready_o  block accepts a word this cycle
//   data_mask_i   byte enables (present only with BPA_BYTE_MASK_EN)
//   cnt_o         total set bits in the frame (saturating)
//   cnt_val_o     cnt_o / ovf_o valid
//   cnt_ready_i   downstream accepts the result
//   ovf_o         frame count saturated, qualified by cnt_val_o
//
// Optional feature: define BPA_BYTE_MASK_EN to add data_mask_i; bit b of
// data_i is then counted only when data_mask_i[b/8] is 1.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A held result stalls the whole pipeline (stall = cnt_val_o &&
// !cnt_ready_i), so data_ready_o = !stall once out of reset; nothing inside
// moves while stalled, so no word is lost or repeated.

module bit_population_accumulator #(
  parameter int WIDTH     = 64,
  parameter int PIPE_SIZE = 2,
  parameter int CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               data_last_i,
  input  logic               data_val_i,
  output logic               data_ready_o,
`ifdef BPA_BYTE_MASK_EN
  input  logic [WIDTH/8-1:0] data_mask_i,
`endif
  output logic [CNT_W-1:0]   cnt_o,
  output logic               cnt_val_o,
  input  logic               cnt_ready_i,
  output logic               ovf_o
);

  localparam int CW  = $clog2(WIDTH) + 1;        // per-word count width
  localparam int NG0 = 1 << (PIPE_SIZE - 1);     // groups in first tree stage
  localparam int GW  = (WIDTH + NG0 - 1) / NG0;  // bits per first-stage group

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t           state_q;
  logic             run_q;       // 0 in reset, 1 from first edge after release
  logic             stall;
  logic [WIDTH-1:0] masked;

  logic [WIDTH-1:0] in_q;
  logic             in_vld_q;
  logic             in_last_q;

  logic [CNT_W-1:0] acc_q;
  logic             sat_q;       // sticky: frame already clamped
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_val_q;
  logic             ovf_q;

  assign stall        = cnt_val_q && !cnt_ready_i;
  assign data_ready_o = run_q && !stall;
  assign cnt_o        = cnt_q;
  assign cnt_val_o    = cnt_val_q;
  assign ovf_o        = ovf_q;

  always_comb begin
    masked = data_i;
`ifdef BPA_BYTE_MASK_EN
    for (int b = 0; b < WIDTH; b++) masked[b] = data_i[b] & data_mask_i[b/8];
`endif
  end

  // Input register: the word is captured on acceptance.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      in_q      <= '0;
      in_vld_q  <= 1'b0;
      in_last_q <= 1'b0;
    end else if (!stall) begin
      in_vld_q <= data_val_i && run_q;
      if (data_val_i && run_q) begin
        in_q      <= masked;
        in_last_q <= data_last_i;
      end
    end
  end

  // First tree level: popcount of contiguous bit groups of the held word.
  logic [CW-1:0] grp_cnt [NG0];
  always_comb begin
    for (int g = 0; g < NG0; g++) grp_cnt[g] = '0;
    for (int b = 0; b < WIDTH; b++)
      grp_cnt[b / GW] = grp_cnt[b / GW] + CW'(in_q[b]);
  end

  // Tree stage s holds NG0>>s partial sums; each later stage adds pairs.
  for (genvar s = 0; s < PIPE_SIZE; s++) begin : g_stg
    localparam int NG = NG0 >> s;
    logic [CW-1:0] sum_q [NG];
    logic [CW-1:0] nxt   [NG];
    logic          vld_q;
    logic          last_q;
    logic          src_vld;
    logic          src_last;

    if (s == 0) begin : g_src
      always_comb begin
        for (int g = 0; g < NG; g++) nxt[g] = grp_cnt[g];
      end
      assign src_vld  = in_vld_q;
      assign src_last = in_last_q;
    end else begin : g_src
      always_comb begin
        for (int g = 0; g < NG; g++)
          nxt[g] = g_stg[s-1].sum_q[2*g] + g_stg[s-1].sum_q[2*g+1];
      end
      assign src_vld  = g_stg[s-1].vld_q;
      assign src_last = g_stg[s-1].last_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
        for (int g = 0; g < NG; g++) sum_q[g] <= '0;
      end else if (!stall) begin
        vld_q  <= src_vld;
        last_q <= src_last;
        for (int g = 0; g < NG; g++) sum_q[g] <= nxt[g];
      end
    end
  end

  logic [CW-1:0]    word_cnt;
  logic             tree_vld;
  logic             tree_last;
  logic             take;
  logic [CNT_W:0]   sum_ext;
  logic             clamp;
  logic [CNT_W-1:0] sum_sat;

  assign word_cnt  = g_stg[PIPE_SIZE-1].sum_q[0];
  assign tree_vld  = g_stg[PIPE_SIZE-1].vld_q;
  assign tree_last = g_stg[PIPE_SIZE-1].last_q;
  assign take      = tree_vld && !stall;
  assign sum_ext   = {1'b0, acc_q} + (CNT_W+1)'(word_cnt);
  assign clamp     = sum_ext[CNT_W];
  assign sum_sat   = clamp ? {CNT_W{1'b1}} : sum_ext[CNT_W-1:0];

  // Accumulator FSM. The word-take update is written after the state case so
  // a last word leaving the tree in the handshake cycle overrides the clear
  // of cnt_val_q (back-to-back results).
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= ST_ACC;
      run_q     <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      cnt_q     <= '0;
      cnt_val_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        ST_ACC: ;
        ST_OUT: begin
          if (cnt_ready_i) begin
            cnt_val_q <= 1'b0;
            state_q   <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
      if (take) begin
        if (tree_last) begin
          cnt_q     <= sum_sat;
          ovf_q     <= sat_q | clamp;
          cnt_val_q <= 1'b1;
          acc_q     <= '0;
          sat_q     <= 1'b0;
          state_q   <= ST_OUT;
        end else begin
          acc_q <= sum_sat;
          sat_q <= sat_q | clamp;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_population_accumulator.sv
// Testbench for bit_population_accumulator: two instances (CNT_W=16 and
// CNT_W=7) share the same input stream; a frame-level reference model feeds
// one expected queue per instance.

module tb_bit_population_accumulator;

  localparam int W = 64;
  localparam int P = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]   data = '0;
  logic           last = 1'b0;
  logic           data_val = 1'b0;
  logic [W/8-1:0] mask = '1;
  logic           cnt_ready = 1'b1;

  logic        rdy16, val16, ovf16, rdy7, val7, ovf7;
  logic [15:0] cnt16;
  logic [6:0]  cnt7;

  bit_population_accumulator #(.WIDTH(W), .PIPE_SIZE(P), .CNT_W(16)) u_dut (
    .clk_i(clk), .arst_n_i(rst_n), .data_i(data), .data_last_i(last),
    .data_val_i(data_val), .data_ready_o(rdy16),
`ifdef BPA_BYTE_MASK_EN
    .data_mask_i(mask),
`endif
    .cnt_o(cnt16), .cnt_val_o(val16), .cnt_ready_i(cnt_ready), .ovf_o(ovf16)
  );

  bit_population_accumulator #(.WIDTH(W), .PIPE_SIZE(P), .CNT_W(7)) u_dut7 (
    .clk_i(clk), .arst_n_i(rst_n), .data_i(data), .data_last_i(last),
    .data_val_i(data_val), .data_ready_o(rdy7),
`ifdef BPA_BYTE_MASK_EN
    .data_mask_i(mask),
`endif
    .cnt_o(cnt7), .cnt_val_o(val7), .cnt_ready_i(cnt_ready), .ovf_o(ovf7)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp16_q[$];  // {ovf, cnt}
  logic [7:0]  exp7_q[$];
  int frame_sum = 0;
  bit rnd_ready = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [W-1:0] expand(input logic [W/8-1:0] m);
    logic [W-1:0] e;
    for (int b = 0; b < W; b++) e[b] = m[b/8];
    return e;
  endfunction

  // Reference model: a frame's result is the total of set (enabled) bits,
  // clamped to the counter maximum, flagged when the total exceeds it.
  task automatic model_word(input logic [W-1:0] d, input logic l, input logic [W/8-1:0] m);
    logic [W-1:0] eff;
`ifdef BPA_BYTE_MASK_EN
    eff = d & expand(m);
`else
    eff = d;
    if (m != m) eff = '0;
`endif
    frame_sum += $countones(eff);
    if (l) begin
      exp16_q.push_back(frame_sum > 65535 ? {1'b1, 16'hFFFF} : {1'b0, 16'(frame_sum)});
      exp7_q.push_back(frame_sum > 127 ? {1'b1, 7'h7F} : {1'b0, 7'(frame_sum)});
      frame_sum = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && val16 && cnt_ready) begin
      if (exp16_q.size() == 0) check("unexpected_result16", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = exp16_q.pop_front();
        check("cnt16", 32'(cnt16), 32'(e[15:0]));
        check("ovf16", 32'(ovf16), 32'(e[16]));
      end
    end
    if (rst_n && val7 && cnt_ready) begin
      if (exp7_q.size() == 0) check("unexpected_result7", 32'd1, 32'd0);
      else begin
        logic [7:0] e;
        e = exp7_q.pop_front();
        check("cnt7", 32'(cnt7), 32'(e[6:0]));
        check("ovf7", 32'(ovf7), 32'(e[7]));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      if (rnd_ready) cnt_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks (entered/left at posedge + 1) ----------------
  task automatic send_word(input logic [W-1:0] d, input logic l, input logic [W/8-1:0] m);
    int n;
    bit ok;
    data = d; last = l; mask = m; data_val = 1'b1;
    n = 0; ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (rdy16) ok = 1;
      else n++;
    end
    @(posedge clk); #1;
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
    else model_word(d, l, m);
    data_val = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp16_q.size() != 0 || exp7_q.size() != 0) && n < 500) begin
      idle(1); n++;
    end
    check("drain_timeout", 32'(exp16_q.size() + exp7_q.size()), 32'd0);
    idle(P + 3);
  endtask

  function automatic logic [W-1:0] rnd_word();
    int k;
    k = $urandom_range(0, 5);
    if (k == 0) return '0;
    if (k == 1) return '1;
    return {$urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt", 32'(cnt16), 32'd0);
    check("rst_val", 32'(val16), 32'd0);
    check("rst_ovf", 32'(ovf16), 32'd0);
    check("rst_ready", 32'(rdy16), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(rdy16), 32'd1);

    // latency of a single all-ones word
    send_word('1, 1'b1, '1);
    check("lat_e0", 32'(val16), 32'd0);
    idle(1); check("lat_e1", 32'(val16), 32'd0);
    idle(1); check("lat_e2", 32'(val16), 32'd0);
    idle(1); check("lat_e3", 32'(val16), 32'd1);
    check("lat_cnt", 32'(cnt16), 32'd64);
    check("lat_ovf", 32'(ovf16), 32'd0);
    wait_drain();

    // 3-word frame back-to-back then a 1-word frame
    send_word(64'h1, 1'b0, '1);
    send_word(64'h3, 1'b0, '1);
    send_word(64'h0, 1'b1, '1);
    send_word(64'hF0, 1'b1, '1);
    // saturation on the 7-bit instance, then recovery
    send_word('1, 1'b0, '1);
    send_word('1, 1'b1, '1);
    send_word(64'h1, 1'b1, '1);
    // sticky clamp across a trailing zero word
    send_word('1, 1'b0, '1);
    send_word('1, 1'b0, '1);
    send_word('0, 1'b1, '1);
`ifdef BPA_BYTE_MASK_EN
    send_word('1, 1'b1, 8'h0F);
`endif
    wait_drain();

    // result held with cnt_ready low for 10 cycles while words are offered
    cnt_ready = 1'b0;
    send_word(64'hFF00_0000_0000_0001, 1'b1, '1);
    begin
      int n;
      n = 0;
      while (!val16 && n < 20) begin idle(1); n++; end
      check("stall_result_seen", 32'(val16), 32'd1);
    end
    fork
      begin
        send_word(64'h7, 1'b0, '1);
        send_word(64'h3, 1'b1, '1);
        send_word(64'hF, 1'b1, '1);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          check("stall_ready", 32'(rdy16), 32'd0);
          check("stall_hold", 32'(cnt16), 32'(exp16_q[0][15:0]));
        end
        @(posedge clk); #1;
        cnt_ready = 1'b1;
      end
    join
    wait_drain();

    // reset in the middle of a frame
    send_word({$urandom, $urandom}, 1'b0, '1);
    send_word('1, 1'b0, '1);
    idle(1);
    #1 rst_n = 1'b0;
    frame_sum = 0;
    #1;
    check("midrst_cnt", 32'(cnt16), 32'd0);
    check("midrst_val", 32'(val16), 32'd0);
    check("midrst_ready", 32'(rdy16), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_back", 32'(rdy16), 32'd1);
    send_word(64'h1, 1'b1, '1);
    wait_drain();

    // random frames with random gaps and random downstream backpressure
    rnd_ready = 1;
    for (int f = 0; f < 100; f++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        logic [W/8-1:0] m;
`ifdef BPA_BYTE_MASK_EN
        m = W'(($urandom_range(0, 1) == 0) ? '1 : $urandom);
`else
        m = '1;
`endif
        send_word(rnd_word(), (i == len - 1), m);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    rnd_ready = 0;
    idle(1);
    cnt_ready = 1'b1;
    wait_drain();

    check("final_q16_empty", 32'(exp16_q.size()), 32'd0);
    check("final_q7_empty", 32'(exp7_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
